// File: rtl/video_pkg.sv
// Shared video types and helpers for the framebuffer scan-out path:
// framebuffer geometry derivation, RGB888 pixel struct and RGB565 expansion.
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic int fb_dim(input int active, input int scale_log2);
    return active >> scale_log2;
  endfunction

  function automatic int fb_addr_w(input int fb_w, input int fb_h);
    return $clog2(fb_w * fb_h);
  endfunction

  // Replicating the top bits fills the low bits so full-scale maps to 0xFF.
  function automatic rgb888_t rgb565_to_888(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5], p[10:9]};
    c.b = {p[4:0], p[4:2]};
    return c;
  endfunction

endpackage

// File: rtl/fb_scanout_sync_delay.sv
// WIDTH x DEPTH shift register with synchronous active-low clear; carries the
// timing flags alongside the framebuffer read so they line up with colour.
module sync_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = d;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!clr_n) sr_q[i] <= '0;
      else        sr_q[i] <= sr_d[i];
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scan-out: scaled/scrolled BRAM addressing, RGB565->RGB888 colour,
// sync delay matching. Define FB_SCANOUT_PALETTE_EN for a 16-entry palette.
module fb_scanout
  import video_pkg::*;
#(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int H_COUNT_W       = 11,
  parameter int V_COUNT_W       = 10,
  parameter int SCALE_LOG2      = 2,
  parameter int BRAM_LATENCY    = 2,
  localparam int FB_W      = fb_dim(ACTIVE_H_PIXELS, SCALE_LOG2),
  localparam int FB_H      = fb_dim(ACTIVE_LINES, SCALE_LOG2),
  localparam int SX_W      = $clog2(FB_W),
  localparam int SY_W      = $clog2(FB_H),
  localparam int FB_ADDR_W = fb_addr_w(FB_W, FB_H)
) (
  input  logic                 clk_pixel_in,
  input  logic                 rst_n_in,
  input  logic [H_COUNT_W-1:0] hcount_in,
  input  logic [V_COUNT_W-1:0] vcount_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic                 ad_in,
  input  logic                 nf_in,
  input  logic [SX_W-1:0]      scroll_x_in,
  input  logic [SY_W-1:0]      scroll_y_in,
  input  logic                 scroll_we_in,
  output logic [FB_ADDR_W-1:0] fb_addr_out,
  output logic                 fb_rd_out,
  input  logic [15:0]          fb_data_in,
`ifdef FB_SCANOUT_PALETTE_EN
  input  logic                 pal_we_in,
  input  logic [3:0]           pal_addr_in,
  input  logic [23:0]          pal_data_in,
`endif
  output logic [7:0]           red_out,
  output logic [7:0]           green_out,
  output logic [7:0]           blue_out,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 ad_out,
  output logic                 scroll_err_out
);

  localparam int XS_W = H_COUNT_W + 1;
  localparam int YS_W = V_COUNT_W + 1;

  logic [SX_W-1:0]      scroll_x_q, scroll_x_d, pend_x_q, pend_x_d;
  logic [SY_W-1:0]      scroll_y_q, scroll_y_d, pend_y_q, pend_y_d;
  logic                 scroll_err_q, scroll_err_d;
  logic                 wr_bad, wr_ok;

  logic [XS_W-1:0]      x_sum, x_wrap;
  logic [YS_W-1:0]      y_sum, y_wrap;
  logic [SX_W-1:0]      fb_x;
  logic [SY_W-1:0]      fb_y;
  logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic                 fb_rd_q, fb_rd_d;

  logic                 hs_b, vs_b, ad_b;
  rgb888_t              pix_d, pix_q;
  logic                 hs_q, vs_q, ad_q;

  // Scroll: an out-of-range write is dropped whole; active only moves on nf.
  always_comb begin
    wr_bad       = scroll_we_in && ((32'(scroll_x_in) >= 32'(FB_W)) ||
                                    (32'(scroll_y_in) >= 32'(FB_H)));
    wr_ok        = scroll_we_in && !wr_bad;
    pend_x_d     = wr_ok ? scroll_x_in : pend_x_q;
    pend_y_d     = wr_ok ? scroll_y_in : pend_y_q;
    scroll_x_d   = nf_in ? pend_x_d : scroll_x_q;
    scroll_y_d   = nf_in ? pend_y_d : scroll_y_q;
    scroll_err_d = scroll_err_q | wr_bad;
  end

  // Stage A: scaled position plus scroll, wrapped by one compare-subtract.
  always_comb begin
    x_sum     = XS_W'(hcount_in >> SCALE_LOG2) + XS_W'(scroll_x_q);
    y_sum     = YS_W'(vcount_in >> SCALE_LOG2) + YS_W'(scroll_y_q);
    x_wrap    = (x_sum >= XS_W'(FB_W)) ? x_sum - XS_W'(FB_W) : x_sum;
    y_wrap    = (y_sum >= YS_W'(FB_H)) ? y_sum - YS_W'(FB_H) : y_sum;
    fb_x      = SX_W'(x_wrap);
    fb_y      = SY_W'(y_wrap);
    fb_addr_d = ad_in ? FB_ADDR_W'(32'(fb_y) * 32'(FB_W) + 32'(fb_x)) : fb_addr_q;
    fb_rd_d   = ad_in;
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      scroll_x_q   <= '0;
      scroll_y_q   <= '0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      scroll_err_q <= 1'b0;
      fb_addr_q    <= '0;
      fb_rd_q      <= 1'b0;
    end else begin
      scroll_x_q   <= scroll_x_d;
      scroll_y_q   <= scroll_y_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      scroll_err_q <= scroll_err_d;
      fb_addr_q    <= fb_addr_d;
      fb_rd_q      <= fb_rd_d;
    end
  end

  // Stage B: flags wait out stage A plus the BRAM read latency.
  sync_delay #(
    .WIDTH (3),
    .DEPTH (BRAM_LATENCY + 1)
  ) u_sync_delay (
    .clk   (clk_pixel_in),
    .clr_n (rst_n_in),
    .d     ({hs_in, vs_in, ad_in}),
    .q     ({hs_b, vs_b, ad_b})
  );

`ifdef FB_SCANOUT_PALETTE_EN
  logic [23:0] pal_q [16];
  logic [23:0] pal_d [16];

  always_comb begin
    for (int i = 0; i < 16; i++) pal_d[i] = pal_q[i];
    if (pal_we_in) pal_d[pal_addr_in] = pal_data_in;
  end

  always_ff @(posedge clk_pixel_in) begin
    for (int i = 0; i < 16; i++) begin
      if (!rst_n_in) pal_q[i] <= '0;
      else           pal_q[i] <= pal_d[i];
    end
  end
`endif

  // Stage C: colour lookup, blanked outside the active area.
  always_comb begin
    pix_d = '0;
    if (ad_b) begin
`ifdef FB_SCANOUT_PALETTE_EN
      pix_d = rgb888_t'(pal_q[fb_data_in[3:0]]);
`else
      pix_d = rgb565_to_888(fb_data_in);
`endif
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      pix_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      ad_q  <= 1'b0;
    end else begin
      pix_q <= pix_d;
      hs_q  <= hs_b;
      vs_q  <= vs_b;
      ad_q  <= ad_b;
    end
  end

  assign fb_addr_out    = fb_addr_q;
  assign fb_rd_out      = fb_rd_q;
  assign red_out        = pix_q.r;
  assign green_out      = pix_q.g;
  assign blue_out       = pix_q.b;
  assign hs_out         = hs_q;
  assign vs_out         = vs_q;
  assign ad_out         = ad_q;
  assign scroll_err_out = scroll_err_q;

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Pixel-clock stage directly downstream of the video timing generator; consumes hcount/vcount/hs/vs/ad/nf.
- Maps each active pixel to an address in a down-scaled framebuffer BRAM, with per-frame X/Y scroll and wrap-around.
- Expands returned RGB565 words to RGB888.
- Delays hs/vs/ad so they stay aligned with the colour going to the TMDS encoder.

Parameters:
- ACTIVE_H_PIXELS, 1280, active pixels per line.
- ACTIVE_LINES, 720, active lines per frame.
- H_COUNT_W, 11, width of hcount_in.
- V_COUNT_W, 10, width of vcount_in.
- SCALE_LOG2, 2, upscale factor 2^SCALE_LOG2 in both axes (FB_W=320, FB_H=180 by default).
- BRAM_LATENCY, 2, read latency in cycles from fb_addr_out to fb_data_in (valid range 1..4).

Ports:
- clk_pixel_in  in  1  pixel clock
- rst_n_in  in  1  reset; one clock, synchronous, active-low
- hcount_in  in  H_COUNT_W  horizontal position from timing generator
- vcount_in  in  V_COUNT_W  vertical position
- hs_in  in  1  hsync
- vs_in  in  1  vsync
- ad_in  in  1  active-drawing flag
- nf_in  in  1  new-frame pulse, 1 cycle
- scroll_x_in  in  $clog2(FB_W)  requested X scroll
- scroll_y_in  in  $clog2(FB_H)  requested Y scroll
- scroll_we_in  in  1  write strobe for the scroll request
- fb_addr_out  out  $clog2(FB_W*FB_H)  BRAM read address
- fb_rd_out  out  1  BRAM read enable
- fb_data_in  in  16  RGB565 pixel from BRAM
- red_out, green_out, blue_out  out  8 each  pixel colour
- hs_out, vs_out, ad_out  out  1 each  delayed syncs
- scroll_err_out  out  1  sticky: illegal scroll write rejected

Behaviour:
Reset:
- While rst_n_in=0 at a clock edge: all outputs 0, delay pipelines cleared, active and pending scroll 0, scroll_err_out 0.
- Reset asserted mid-frame flushes the pipeline with no partial pixels emitted.

Stage A (1 cycle, registered):
- fb_x = (hcount_in>>SCALE_LOG2) + scroll_x_active; subtract FB_W once if the sum is >= FB_W.
- fb_y computed likewise with FB_H.
- fb_addr_out <= fb_y*FB_W + fb_x; fb_rd_out <= ad_in.
- When ad_in=0, fb_addr_out holds its previous value.
- FB_W and FB_H are not powers of two; wrap by compare-subtract, never by truncation.

Stage B:
- fb_data_in is valid BRAM_LATENCY cycles after fb_addr_out.

Stage C (1 cycle, registered):
- ad delayed=1: red = {R5,R5[4:2]}, green = {G6,G6[5:4]}, blue = {B5,B5[4:2]}.
- ad delayed=0: RGB = 0.

Latency:
- Total latency is BRAM_LATENCY+2 cycles from the timing inputs to all outputs.
- hs/vs/ad pass through an identical-length delay line.

Scroll:
- A scroll_we_in write updates the pending registers.
- Pending values are copied to active on nf_in=1. Active never changes mid-frame.
- scroll_we_in and nf_in in the same cycle: the new value goes to both pending and active.
- scroll_x_in >= FB_W or scroll_y_in >= FB_H: the whole write is dropped and scroll_err_out is set.
- scroll_err_out clears only on reset.

Optional Feature:
- Macro FB_SCANOUT_PALETTE_EN.
- Defined:
  - Adds ports pal_we_in, pal_addr_in[3:0], pal_data_in[23:0], a 16x24-bit register palette.
  - Stage C outputs palette[fb_data_in[3:0]] as {R,G,B}; latency is unchanged.
  - A palette write takes effect on the next pixel.
  - Palette resets to all 0.
- Undefined: RGB565 expansion as specified, and no palette ports.

Decomposition:
- video_pkg:
  - FB_W/FB_H derivation, FB_ADDR_W
  - rgb888_t struct
  - rgb565_to_888 function
- Sub-module: sync_delay, a parameterised N-bit x DEPTH shift register with synchronous active-low clear. It carries {hs,vs,ad} through stages A–C.

Test Plan:
All scenarios use defaults, so latency = 4.
1. rst_n_in=0 for 3 cycles with ad_in=1, hcount sweeping -> all outputs 0, including fb_rd_out. Release -> first ad_out=1 exactly 4 cycles after first ad_in=1.
2. Scroll 0, vcount=0, hcount 0..7 -> fb_addr_out 0,0,0,0,1,1,1,1 starting one cycle later. vcount=4, hcount=0 -> address 320.
3. Write scroll_x=319 then pulse nf_in; hcount=4 (fb_x 1+319) -> wraps to 0. scroll_y=179 with vcount=4 -> fb_y 0.
4. scroll_we_in with x=10 at vcount=100 -> addresses unchanged for the rest of the frame. After nf_in, first active pixel address = 10.
5. scroll_x_in=320 written -> write ignored, scroll_err_out=1 and stays 1 until reset. Simultaneous nf_in does not apply it.
6. fb_data_in=0xF800 with ad -> RGB FF/00/00; 0x07E0 -> 00/FF/00; ad_in=0 -> 00/00/00. Palette build: entry 5 = 0x123456, data 0x0005 -> RGB 12/34/56.
